// File: rtl/dnn_pkg.sv
// dnn_pkg: shared types, widths and helpers for the two-layer DNN scheduler.
//   state_t       : scheduler FSM states
//   DATA_W/ACC_W  : sample width and MAC accumulator width
//   SAT_MAX/MIN   : 16-bit saturation limits for neuron results
//   w_base()      : first weight-ROM address of a neuron
//   sat16()       : clamp a widened accumulator value to 16 bits
package dnn_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    H_MAC    = 3'd1,
    H_STORE  = 3'd2,
    O_MAC    = 3'd3,
    O_STORE  = 3'd4,
    ARGMAX   = 3'd5,
    FIN      = 3'd6
  } state_t;

  localparam int DATA_W        = 16;
  localparam int PROD_W        = 32;
  localparam int ACC_W         = 40;
  localparam int FRAC_BITS_DEF = 8;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  // Hidden weights are stored neuron-major first, output weights follow them.
  function automatic int w_base(input logic out_layer, input int n,
                                input int in_size, input int hidden);
    int base;
    if (out_layer) begin
      base = hidden * in_size + n * hidden;
    end else begin
      base = n * in_size;
    end
    return base;
  endfunction

  // Clamp to the signed 16-bit range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > 41'sd32767) begin
      r = SAT_MAX;
    end else if (v < -41'sd32768) begin
      r = SAT_MIN;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dnn_mac.sv
// dnn_mac: signed 16x16 multiply with a saturating 40-bit accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of the accumulator (wins over en)
//   en         : add a*b into the accumulator this cycle
//   a, b       : signed 16-bit operands
//   acc        : signed 40-bit accumulator value
// The add saturates instead of wrapping: a full image of maximum-magnitude
// pixels and weights exceeds 40 bits, and a wrapped sum would flip sign.
module dnn_mac
  import dnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W:0]    sum_s;
  logic signed [ACC_W-1:0]  sat_s;
  logic signed [ACC_W-1:0]  acc_r;

  // Product, widened sum and overflow clamp.
  always_comb begin
    prod_s = a * b;
    sum_s  = 41'(acc_r) + 41'(prod_s);
    if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
      sat_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_s = sum_s[ACC_W-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 40'sd0;
    end else if (clear) begin
      acc_r <= 40'sd0;
    end else if (en) begin
      acc_r <= sat_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/dnn_layer_sched.sv
// dnn_layer_sched: sequences one inference of a two-layer fully connected
// network (hidden layer with ReLU, output layer, argmax).
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request one inference (accepted only in IDLE)
//   px_addr / px_data : pixel memory, data one cycle after address
//   w_addr  / w_data  : weight ROM, data one cycle after address
//   b_addr  / b_data  : bias ROM, data one cycle after address
//   busy              : inference in progress (low in IDLE and FIN)
//   done              : one-cycle pulse when final_digit updates
//   final_digit       : argmax of the last completed inference
module dnn_layer_sched
  import dnn_pkg::*;
#(
  parameter  int INPUT_SIZE     = 784,
  parameter  int HIDDEN_NEURONS = 10,
  parameter  int OUTPUT_NEURONS = 10,
  parameter  int FRAC_BITS      = FRAC_BITS_DEF,
  localparam int PX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int W_W  = $clog2(HIDDEN_NEURONS*INPUT_SIZE + OUTPUT_NEURONS*HIDDEN_NEURONS),
  localparam int B_W  = $clog2(HIDDEN_NEURONS + OUTPUT_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [PX_W-1:0]          px_addr,
  input  logic signed [DATA_W-1:0] px_data,
  output logic [W_W-1:0]           w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [B_W-1:0]           b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               final_digit
);

  localparam int MAX_HO  = (HIDDEN_NEURONS > OUTPUT_NEURONS) ? HIDDEN_NEURONS : OUTPUT_NEURONS;
  localparam int MAX_LEN = (INPUT_SIZE > MAX_HO) ? INPUT_SIZE : MAX_HO;
  localparam int K_W     = $clog2(MAX_LEN + 1);
  localparam int N_W     = $clog2(MAX_HO + 1);

  state_t state_r, next_state_s;

  logic [K_W-1:0]  k_r;          // issue / scan counter within a state
  logic [K_W-1:0]  act_sel_r;    // input index whose data arrives this cycle
  logic [N_W-1:0]  n_r;          // neuron index within the current layer
  logic [PX_W-1:0] px_addr_r;
  logic [W_W-1:0]  w_addr_r;
  logic [B_W-1:0]  b_addr_r;
  logic            mac_en_r;
  logic            busy_r;
  logic            done_r;
  logic [3:0]      final_digit_r;

  logic signed [DATA_W-1:0] act_r   [HIDDEN_NEURONS];
  logic signed [DATA_W-1:0] score_r [OUTPUT_NEURONS];
  logic signed [DATA_W-1:0] best_val_r;
  logic [3:0]               best_idx_r;

  logic                     issue_s;
  logic                     clear_s;
  logic                     busy_nxt_s;
  logic                     last_h_s;
  logic                     last_o_s;
  logic signed [DATA_W-1:0] act_val_s;
  logic signed [DATA_W-1:0] mac_a_s;
  logic signed [DATA_W-1:0] cand_s;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W:0]    bias_sh_s;
  logic signed [ACC_W:0]    sum_s;
  logic signed [ACC_W:0]    shr_s;
  logic signed [DATA_W-1:0] res_s;
  logic signed [DATA_W-1:0] relu_s;

  assign last_h_s = (n_r == N_W'(HIDDEN_NEURONS - 1));
  assign last_o_s = (n_r == N_W'(OUTPUT_NEURONS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; each MAC state runs its issue cycles plus one drain cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = start ? H_MAC : IDLE;
      H_MAC:   next_state_s = (k_r == K_W'(INPUT_SIZE)) ? H_STORE : H_MAC;
      H_STORE: next_state_s = last_h_s ? O_MAC : H_MAC;
      O_MAC:   next_state_s = (k_r == K_W'(HIDDEN_NEURONS)) ? O_STORE : O_MAC;
      O_STORE: next_state_s = last_o_s ? ARGMAX : O_MAC;
      ARGMAX:  next_state_s = (k_r == K_W'(OUTPUT_NEURONS - 1)) ? FIN : ARGMAX;
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode: issue strobe, accumulator clear on MAC entry, next busy.
  always_comb begin
    case (state_r)
      H_MAC:   issue_s = (k_r < K_W'(INPUT_SIZE));
      O_MAC:   issue_s = (k_r < K_W'(HIDDEN_NEURONS));
      default: issue_s = 1'b0;
    endcase
    clear_s    = ((next_state_s == H_MAC) && (state_r != H_MAC)) ||
                 ((next_state_s == O_MAC) && (state_r != O_MAC));
    busy_nxt_s = (next_state_s != IDLE) && (next_state_s != FIN);
  end

  // Counters and registered memory addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r       <= '0;
      act_sel_r <= '0;
      n_r       <= '0;
      px_addr_r <= '0;
      w_addr_r  <= '0;
      b_addr_r  <= '0;
      mac_en_r  <= 1'b0;
    end else begin
      act_sel_r <= k_r;
      mac_en_r  <= issue_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            k_r       <= '0;
            n_r       <= '0;
            px_addr_r <= '0;
            w_addr_r  <= W_W'(w_base(1'b0, 0, INPUT_SIZE, HIDDEN_NEURONS));
            b_addr_r  <= '0;
          end else begin
            k_r <= k_r;
          end
        end
        H_MAC: begin
          k_r <= k_r + K_W'(1);
          if (k_r < K_W'(INPUT_SIZE - 1)) begin
            px_addr_r <= px_addr_r + PX_W'(1);
            w_addr_r  <= w_addr_r + W_W'(1);
          end else begin
            px_addr_r <= px_addr_r;
          end
        end
        H_STORE: begin
          k_r       <= '0;
          px_addr_r <= '0;
          if (last_h_s) begin
            n_r      <= '0;
            w_addr_r <= W_W'(w_base(1'b1, 0, INPUT_SIZE, HIDDEN_NEURONS));
            b_addr_r <= B_W'(HIDDEN_NEURONS);
          end else begin
            n_r      <= n_r + N_W'(1);
            w_addr_r <= W_W'(w_base(1'b0, int'(n_r) + 1, INPUT_SIZE, HIDDEN_NEURONS));
            b_addr_r <= B_W'(int'(n_r) + 1);
          end
        end
        O_MAC: begin
          k_r <= k_r + K_W'(1);
          if (k_r < K_W'(HIDDEN_NEURONS - 1)) begin
            w_addr_r <= w_addr_r + W_W'(1);
          end else begin
            w_addr_r <= w_addr_r;
          end
        end
        O_STORE: begin
          k_r <= '0;
          if (last_o_s) begin
            n_r <= '0;
          end else begin
            n_r      <= n_r + N_W'(1);
            w_addr_r <= W_W'(w_base(1'b1, int'(n_r) + 1, INPUT_SIZE, HIDDEN_NEURONS));
            b_addr_r <= B_W'(HIDDEN_NEURONS + int'(n_r) + 1);
          end
        end
        ARGMAX:  k_r <= k_r + K_W'(1);
        FIN:     k_r <= '0;
        default: k_r <= '0;
      endcase
    end
  end

  // Operand select: output-layer inputs come from the act buffer, aligned to w_data.
  always_comb begin
    act_val_s = 16'sh0000;
    for (int i = 0; i < HIDDEN_NEURONS; i++) begin
      act_val_s = (act_sel_r == K_W'(i)) ? act_r[i] : act_val_s;
    end
    cand_s = 16'sh0000;
    for (int i = 0; i < OUTPUT_NEURONS; i++) begin
      cand_s = (k_r == K_W'(i)) ? score_r[i] : cand_s;
    end
    if (state_r == O_MAC) begin
      mac_a_s = act_val_s;
    end else begin
      mac_a_s = px_data;
    end
  end

  dnn_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .en    (mac_en_r),
    .a     (mac_a_s),
    .b     (w_data),
    .acc   (acc_s)
  );

  // Neuron result: add bias in accumulator scale, rescale, saturate, optional ReLU.
  always_comb begin
    bias_sh_s = 41'(b_data) <<< FRAC_BITS;
    sum_s     = 41'(acc_s) + bias_sh_s;
    shr_s     = sum_s >>> FRAC_BITS;
    res_s     = sat16(shr_s);
    if (res_s[DATA_W-1]) begin
      relu_s = 16'sh0000;
    end else begin
      relu_s = res_s;
    end
  end

  // Activation and score buffers, written in the STORE states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIDDEN_NEURONS; i++) act_r[i] <= 16'sh0000;
      for (int i = 0; i < OUTPUT_NEURONS; i++) score_r[i] <= 16'sh0000;
    end else begin
      for (int i = 0; i < HIDDEN_NEURONS; i++) begin
        if ((state_r == H_STORE) && (n_r == N_W'(i))) act_r[i] <= relu_s;
      end
      for (int i = 0; i < OUTPUT_NEURONS; i++) begin
        if ((state_r == O_STORE) && (n_r == N_W'(i))) score_r[i] <= res_s;
      end
    end
  end

  // Running argmax; strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_r <= 16'sh0000;
      best_idx_r <= 4'd0;
    end else if ((state_r == ARGMAX) && ((k_r == K_W'(0)) || (cand_s > best_val_r))) begin
      best_val_r <= cand_s;
      best_idx_r <= 4'(k_r);
    end else begin
      best_val_r <= best_val_r;
    end
  end

  // Registered status outputs; the result is published as FIN completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      final_digit_r <= 4'd0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= (state_r == FIN);
      if (state_r == FIN) begin
        final_digit_r <= best_idx_r;
      end else begin
        final_digit_r <= final_digit_r;
      end
    end
  end

  assign px_addr     = px_addr_r;
  assign w_addr      = w_addr_r;
  assign b_addr      = b_addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign final_digit = final_digit_r;

endmodule

// File: tb/tb_dnn_layer_sched.sv
// tb_dnn_layer_sched: directed scenarios for dnn_layer_sched at default
// parameters, with behavioural pixel/weight/bias memories (one-cycle read).
module tb_dnn_layer_sched;

  localparam int I   = 784;
  localparam int H   = 10;
  localparam int O   = 10;
  localparam int LAT = 7991;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [9:0]        px_addr;
  logic signed [15:0] px_data;
  logic [12:0]       w_addr;
  logic signed [15:0] w_data;
  logic [4:0]        b_addr;
  logic signed [15:0] b_data;
  logic              busy;
  logic              done;
  logic [3:0]        final_digit;

  int checks = 0;
  int errors = 0;

  // memory content selectors
  int w_mode  = 0;   // 0: all weights zero, 1: hidden 0x7FFF/0x8001 by neuron parity
  int px_mode = 0;   // 0: small ramp, 1: all 0x7FFF
  int b_mode  = 0;   // 0: only output bias b_idx = 0x0100, 1: all output biases 0x0080
  int b_idx   = 0;

  // observations of one run
  int obs_lat, obs_pulses, obs_busy_bad, obs_addr_bad, obs_bad_k;
  bit obs_saw_7865;

  dnn_layer_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .px_addr     (px_addr),
    .px_data     (px_data),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .busy        (busy),
    .done        (done),
    .final_digit (final_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] px_fn(input logic [9:0] a);
    int ai = int'(a);
    return (px_mode == 1) ? 16'sh7FFF : 16'(ai * 3 + 1);
  endfunction

  function automatic logic signed [15:0] w_fn(input logic [12:0] a);
    int ai = int'(a);
    if (w_mode == 1 && ai < H * I) return (((ai / I) % 2) == 0) ? 16'sh7FFF : 16'sh8001;
    else return 16'sh0000;
  endfunction

  function automatic logic signed [15:0] b_fn(input logic [4:0] a);
    int ai = int'(a);
    if (b_mode == 1) return (ai >= H) ? 16'sh0080 : 16'sh0000;
    else return (ai == H + b_idx) ? 16'sh0100 : 16'sh0000;
  endfunction

  always @(posedge clk) begin
    px_data <= px_fn(px_addr);
    w_data  <= w_fn(w_addr);
    b_data  <= b_fn(b_addr);
  end

  // Pulse start, then observe LAT+5 cycles sampled on the falling edge.
  // k counts rising edges after the one that sampled start.
  task automatic run_to_done(input bit extra_start, input bit fin_start);
    int n, j, kk;
    bit bad;
    obs_lat = -1; obs_pulses = 0; obs_busy_bad = 0; obs_addr_bad = 0;
    obs_bad_k = -1; obs_saw_7865 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        obs_pulses++;
        if (obs_lat < 0) obs_lat = k;
      end
      if (busy !== (k < LAT - 1)) obs_busy_bad++;
      bad = 1'b0;
      if (k < H * (I + 2)) begin
        n = k / (I + 2); j = k % (I + 2);
        if (b_addr !== 5'(n)) bad = 1'b1;
        if (j < I && (px_addr !== 10'(j) || w_addr !== 13'(n * I + j))) bad = 1'b1;
      end else if (k < H * (I + 2) + O * (H + 2)) begin
        kk = k - H * (I + 2); n = kk / (H + 2); j = kk % (H + 2);
        if (b_addr !== 5'(H + n)) bad = 1'b1;
        if (j < H && w_addr !== 13'(H * I + n * H + j)) bad = 1'b1;
        if (n == 2 && j == 5 && w_addr === 13'd7865) obs_saw_7865 = 1'b1;
      end
      if (bad) begin
        obs_addr_bad++;
        if (obs_bad_k < 0) obs_bad_k = k;
      end
      start = (extra_start && k == 100) || (fin_start && k == LAT - 1);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (final_digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", final_digit); end
    checks++; if (px_addr !== 10'd0) begin errors++; $display("FAIL reset_px_addr: got %0d expected 0", px_addr); end
    checks++; if (w_addr !== 13'd0) begin errors++; $display("FAIL reset_w_addr: got %0d expected 0", w_addr); end
    checks++; if (b_addr !== 5'd0) begin errors++; $display("FAIL reset_b_addr: got %0d expected 0", b_addr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_zero_weight_and_addressing;
    w_mode = 0; px_mode = 0; b_mode = 0; b_idx = 3;
    run_to_done(1'b0, 1'b0);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_pulses != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", obs_pulses); end
    checks++; if (obs_busy_bad != 0) begin errors++; $display("FAIL zero_busy_window: got %0d bad cycles expected 0", obs_busy_bad); end
    checks++; if (final_digit !== 4'd3) begin errors++; $display("FAIL zero_digit: got %0d expected 3", final_digit); end
    checks++; if (obs_addr_bad != 0) begin errors++; $display("FAIL addr_sequence: got %0d bad cycles (first k=%0d) expected 0", obs_addr_bad, obs_bad_k); end
    checks++; if (obs_saw_7865 !== 1'b1) begin errors++; $display("FAIL addr_w7865: got %0b expected 1", obs_saw_7865); end
  endtask

  task automatic test_tie_break;
    w_mode = 0; px_mode = 0; b_mode = 1;
    run_to_done(1'b0, 1'b0);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL tie_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (final_digit !== 4'd0) begin errors++; $display("FAIL tie_digit: got %0d expected 0", final_digit); end
  endtask

  task automatic test_saturation_relu;
    logic signed [15:0] exp_act;
    w_mode = 1; px_mode = 1; b_mode = 0; b_idx = 6;
    run_to_done(1'b0, 1'b0);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL sat_latency: got %0d expected %0d", obs_lat, LAT); end
    for (int i = 0; i < H; i++) begin
      exp_act = ((i % 2) == 0) ? 16'sh7FFF : 16'sh0000;
      checks++;
      if (dut.act_r[i] !== exp_act) begin
        errors++; $display("FAIL sat_act[%0d]: got %h expected %h", i, dut.act_r[i], exp_act);
      end
    end
    checks++; if (final_digit !== 4'd6) begin errors++; $display("FAIL sat_digit: got %0d expected 6", final_digit); end
  endtask

  task automatic test_protocol;
    w_mode = 0; px_mode = 0; b_mode = 0; b_idx = 7;
    run_to_done(1'b1, 1'b1);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL proto_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_pulses != 1) begin errors++; $display("FAIL proto_done_pulses: got %0d expected 1", obs_pulses); end
    checks++; if (obs_busy_bad != 0) begin errors++; $display("FAIL proto_busy_window: got %0d bad cycles expected 0", obs_busy_bad); end
    checks++; if (final_digit !== 4'd7) begin errors++; $display("FAIL proto_digit: got %0d expected 7", final_digit); end
  endtask

  task automatic test_reset_abort;
    int seen;
    w_mode = 0; px_mode = 0; b_mode = 0; b_idx = 5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b expected 0", done); end
    checks++; if (final_digit !== 4'd0) begin errors++; $display("FAIL abort_digit: got %0d expected 0", final_digit); end
    checks++; if (px_addr !== 10'd0) begin errors++; $display("FAIL abort_px_addr: got %0d expected 0", px_addr); end
    checks++; if (dut.acc_s !== 40'sd0) begin errors++; $display("FAIL abort_acc: got %0d expected 0", dut.acc_s); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen); end
    run_to_done(1'b0, 1'b0);
    checks++; if (obs_lat != LAT) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_pulses != 1) begin errors++; $display("FAIL restart_done_pulses: got %0d expected 1", obs_pulses); end
    checks++; if (final_digit !== 4'd5) begin errors++; $display("FAIL restart_digit: got %0d expected 5", final_digit); end
  endtask

  initial begin
    test_reset();
    test_zero_weight_and_addressing();
    test_tie_break();
    test_saturation_relu();
    test_protocol();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
